// File: rtl/aqed_out_checker_if.sv
// Handshake bundle between a memory core under test and the A-QED output
// checker. The master side drives the core's input/output traffic and the
// solver mark. The slave side (the checker) returns the verdict flags.
interface aqed_out_checker_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              exec_dup;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_rdy;
  logic              qed_done;
  logic              qed_check;
  logic              overflow;

  modport master (
    output in_valid, in_data, exec_dup, out_valid, out_data, out_rdy,
    input  qed_done, qed_check, overflow
  );

  modport slave (
    input  in_valid, in_data, exec_dup, out_valid, out_data, out_rdy,
    output qed_done, qed_check, overflow
  );
endinterface

// File: rtl/aqed_out_checker.sv
// A-QED functional-consistency output checker.
// A free mark (exec_dup) picks an "original" input. A second mark on an
// input carrying identical data picks its "duplicate". The core outputs at
// the same transaction positions are captured. Once both are captured, the
// checker reports whether they agree. Counters saturate; saturation before
// completion makes the run inconclusive (overflow) and freezes capture.
module aqed_out_checker #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  aqed_out_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ORIG = 2'd1,
    DUP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [CNT_W-1:0]  in_cnt_r;
  logic [CNT_W-1:0]  out_cnt_r;
  logic [CNT_W-1:0]  orig_idx_r;
  logic [CNT_W-1:0]  dup_idx_r;
  logic [DATA_W-1:0] orig_in_r;
  logic [DATA_W-1:0] orig_out_r;
  logic [DATA_W-1:0] dup_out_r;
  logic              orig_got_r;
  logic              dup_got_r;
  logic              qed_done_r;
  logic              qed_check_r;
  logic              overflow_r;

  logic              out_acc_s;
  logic              in_inc_s;
  logic              out_inc_s;
  logic              ovf_set_s;
  logic              live_s;
  logic              mark_orig_s;
  logic              mark_dup_s;
  logic [CNT_W-1:0]  orig_idx_s;
  logic [CNT_W-1:0]  dup_idx_s;
  logic              orig_armed_s;
  logic              dup_armed_s;
  logic              cap_orig_s;
  logic              cap_dup_s;
  logic              done_set_s;

  // Next-cycle decisions: counter steps, marks, bypassed index match, completion.
  always_comb begin
    out_acc_s   = bus.out_valid & bus.out_rdy;
    in_inc_s    = bus.in_valid && (in_cnt_r != CNT_MAX);
    out_inc_s   = out_acc_s && (out_cnt_r != CNT_MAX);
    // Flag the step that lands a counter on its ceiling.
    ovf_set_s   = !qed_done_r &&
                  ((in_inc_s && (in_cnt_r == (CNT_MAX - CNT_ONE))) ||
                   (out_inc_s && (out_cnt_r == (CNT_MAX - CNT_ONE))));
    live_s      = !overflow_r;
    mark_orig_s = 1'b0;
    mark_dup_s  = 1'b0;
    case (state_r)
      IDLE:    mark_orig_s = live_s && bus.in_valid && bus.exec_dup;
      ORIG:    mark_dup_s  = live_s && bus.in_valid && bus.exec_dup &&
                             (bus.in_data == orig_in_r);
      DUP:     mark_dup_s  = 1'b0;
      default: mark_orig_s = 1'b0;
    endcase
    // An index being marked this cycle is already visible to output matching.
    orig_idx_s   = mark_orig_s ? in_cnt_r : orig_idx_r;
    dup_idx_s    = mark_dup_s  ? in_cnt_r : dup_idx_r;
    orig_armed_s = (state_r != IDLE) || mark_orig_s;
    dup_armed_s  = (state_r == DUP) || mark_dup_s;
    cap_orig_s   = live_s && out_acc_s && orig_armed_s && !orig_got_r &&
                   (out_cnt_r == orig_idx_s);
    cap_dup_s    = live_s && out_acc_s && dup_armed_s && !dup_got_r &&
                   (out_cnt_r == dup_idx_s);
    done_set_s   = orig_got_r && dup_got_r && !qed_done_r && live_s && !ovf_set_s;
  end

  // State, counters, captures and registered verdict flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      in_cnt_r    <= {CNT_W{1'b0}};
      out_cnt_r   <= {CNT_W{1'b0}};
      orig_idx_r  <= {CNT_W{1'b0}};
      dup_idx_r   <= {CNT_W{1'b0}};
      orig_in_r   <= {DATA_W{1'b0}};
      orig_out_r  <= {DATA_W{1'b0}};
      dup_out_r   <= {DATA_W{1'b0}};
      orig_got_r  <= 1'b0;
      dup_got_r   <= 1'b0;
      qed_done_r  <= 1'b0;
      qed_check_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      if (in_inc_s) begin
        in_cnt_r <= in_cnt_r + CNT_ONE;
      end
      if (out_inc_s) begin
        out_cnt_r <= out_cnt_r + CNT_ONE;
      end
      if (mark_orig_s) begin
        orig_idx_r <= in_cnt_r;
        orig_in_r  <= bus.in_data;
        state_r    <= ORIG;
      end else if (mark_dup_s) begin
        dup_idx_r <= in_cnt_r;
        state_r   <= DUP;
      end
      if (cap_orig_s) begin
        orig_out_r <= bus.out_data;
        orig_got_r <= 1'b1;
      end
      if (cap_dup_s) begin
        dup_out_r <= bus.out_data;
        dup_got_r <= 1'b1;
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
      if (done_set_s) begin
        qed_done_r  <= 1'b1;
        qed_check_r <= (orig_out_r == dup_out_r);
      end
    end
  end

  assign bus.qed_done  = qed_done_r;
  assign bus.qed_check = qed_check_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_aqed_out_checker.sv
// Directed bench for aqed_out_checker (CNT_W=4 so saturation is reachable).
// Each record is one clock cycle of stimulus plus the flags expected just
// after that cycle's rising edge.
module tb_aqed_out_checker;

  logic clk;
  logic reset;

  aqed_out_checker_if #(.DATA_W(16)) bus();

  aqed_out_checker #(.DATA_W(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        iv;
    logic [15:0] id;
    logic        mk;
    logic        ov;
    logic [15:0] od;
    logic        rdy;
    logic        e_done;
    logic        e_chk;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_miss;

  task automatic add(input string name, input logic rst_n,
                     input logic iv, input logic [15:0] id, input logic mk,
                     input logic ov, input logic [15:0] od, input logic rdy,
                     input logic e_done, input logic e_chk, input logic e_ovf);
    vec_t v;
    v.name = name; v.rst_n = rst_n;
    v.iv = iv; v.id = id; v.mk = mk;
    v.ov = ov; v.od = od; v.rdy = rdy;
    v.e_done = e_done; v.e_chk = e_chk; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset         = v.rst_n;
    bus.in_valid  = v.iv;
    bus.in_data   = v.id;
    bus.exec_dup  = v.mk;
    bus.out_valid = v.ov;
    bus.out_data  = v.od;
    bus.out_rdy   = v.rdy;
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.qed_done, bus.qed_check, bus.overflow} !== {v.e_done, v.e_chk, v.e_ovf}) begin
      n_miss++;
      $display("FAIL %s: done/check/ovf got %b%b%b want %b%b%b", v.name,
               bus.qed_done, bus.qed_check, bus.overflow, v.e_done, v.e_chk, v.e_ovf);
    end
  endtask

  initial begin
    vec_t v;
    n_vec  = 0;
    n_miss = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 16'h0000; bus.exec_dup = 1'b0;
    bus.out_valid = 1'b0; bus.out_data = 16'h0000; bus.out_rdy = 1'b0;

    // Basic pass: 0x11, 0x22(mark), 0x33, 0x22(mark); outputs echo one cycle later.
    add("rst_a",    1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    add("pass_i0",  1'b1, 1'b1, 16'h11, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    add("pass_i1",  1'b1, 1'b1, 16'h22, 1'b1, 1'b1, 16'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    add("pass_i2",  1'b1, 1'b1, 16'h33, 1'b0, 1'b1, 16'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    add("pass_i3",  1'b1, 1'b1, 16'h22, 1'b1, 1'b1, 16'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    add("pass_o3",  1'b1, 1'b0, 16'h00, 1'b0, 1'b1, 16'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    add("pass_dn",  1'b1, 1'b0, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    add("pass_hld", 1'b1, 1'b1, 16'h22, 1'b1, 1'b1, 16'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    // Reset after completion clears everything; corrupted duplicate output.
    add("rst_b",    1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    add("bad_i0",   1'b1, 1'b1, 16'h11, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    add("bad_i1",   1'b1, 1'b1, 16'h22, 1'b1, 1'b1, 16'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    add("bad_i2",   1'b1, 1'b1, 16'h33, 1'b0, 1'b1, 16'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    add("bad_i3",   1'b1, 1'b1, 16'h22, 1'b1, 1'b1, 16'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    add("bad_o3",   1'b1, 1'b0, 16'h00, 1'b0, 1'b1, 16'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    add("bad_dn",   1'b1, 1'b0, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add("bad_hld",  1'b1, 1'b0, 16'h00, 1'b0, 1'b1, 16'h22, 1'b1, 1'b1, 1'b0, 1'b0);
    // Mark on 0x33 while waiting for a 0x22 duplicate must be ignored.
    add("rst_c",    1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    add("neq_i0",   1'b1, 1'b1, 16'h11, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    add("neq_i1",   1'b1, 1'b1, 16'h22, 1'b1, 1'b1, 16'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    add("neq_i2",   1'b1, 1'b1, 16'h33, 1'b1, 1'b1, 16'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    add("neq_i3",   1'b1, 1'b1, 16'h22, 1'b1, 1'b1, 16'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    add("neq_o3",   1'b1, 1'b0, 16'h00, 1'b0, 1'b1, 16'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    add("neq_dn",   1'b1, 1'b0, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    // Mark and matching output in the same cycle (bypass), for both marks.
    add("rst_d",    1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    add("byp_0",    1'b1, 1'b1, 16'h55, 1'b1, 1'b1, 16'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    add("byp_1",    1'b1, 1'b1, 16'h55, 1'b1, 1'b1, 16'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    add("byp_dn",   1'b1, 1'b0, 16'h00, 1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 1'b0);

    foreach (vecs[i]) apply(vecs[i]);

    // Output stall: valid without ready for five cycles must not count or capture.
    v = '{name:"stl_rst", rst_n:1'b0, iv:1'b0, id:16'h00, mk:1'b0, ov:1'b0, od:16'h00,
          rdy:1'b0, e_done:1'b0, e_chk:1'b0, e_ovf:1'b0};
    apply(v);
    v.rst_n = 1'b1; v.name = "stl_mk";
    v.iv = 1'b1; v.id = 16'h11; v.mk = 1'b1;
    apply(v);
    apply(v);
    v.iv = 1'b0; v.mk = 1'b0; v.ov = 1'b1; v.od = 16'h77; v.rdy = 1'b0; v.name = "stl_wait";
    for (int k = 0; k < 5; k++) apply(v);
    v.od = 16'h11; v.rdy = 1'b1; v.name = "stl_go";
    apply(v);
    apply(v);
    v.ov = 1'b0; v.rdy = 1'b0; v.name = "stl_dn"; v.e_done = 1'b1; v.e_chk = 1'b1;
    apply(v);

    // Saturation: 15 unmarked inputs on a 4-bit counter, then nothing completes.
    v = '{name:"ovf_rst", rst_n:1'b0, iv:1'b0, id:16'h00, mk:1'b0, ov:1'b0, od:16'h00,
          rdy:1'b0, e_done:1'b0, e_chk:1'b0, e_ovf:1'b0};
    apply(v);
    v.rst_n = 1'b1; v.iv = 1'b1; v.id = 16'h44; v.name = "ovf_cnt";
    for (int k = 0; k < 14; k++) apply(v);
    v.e_ovf = 1'b1; v.name = "ovf_hit";
    apply(v);
    v.id = 16'h22; v.mk = 1'b1; v.ov = 1'b1; v.od = 16'h22; v.rdy = 1'b1; v.name = "ovf_mk";
    apply(v);
    apply(v);
    v.iv = 1'b0; v.mk = 1'b0; v.ov = 1'b0; v.rdy = 1'b0; v.name = "ovf_idle";
    apply(v);
    apply(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aqed_out_checker.md
AQED_OUT_CHECKER -- requirements
Module: aqed_out_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data width of inputs and outputs.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the transaction index counters.
REQ-003 SHALL have port clk  input  1  meaning single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-low reset; clk is the only clock.
REQ-005 SHALL have port in_valid  input  1  meaning an input transaction is accepted by the memory core this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  meaning data of the accepted input transaction.
REQ-007 SHALL have port exec_dup  input  1  meaning free (solver-driven) mark selecting the current input as original or duplicate.
REQ-008 SHALL have port out_valid  input  1  meaning the memory core presents an output this cycle.
REQ-009 SHALL have port out_data  input  DATA_W  meaning memory core output data.
REQ-010 SHALL have port out_rdy  input  1  meaning the consumer accepts out_data this cycle.
REQ-011 SHALL have port qed_done  output  1  meaning original and duplicate outputs both captured.
REQ-012 SHALL have port qed_check  output  1  meaning captured original output equals captured duplicate output.
REQ-013 SHALL have port overflow  output  1  meaning sticky flag: a counter saturated before completion.

Function
REQ-014 SHALL count accepted inputs (in_valid=1) in in_cnt and accepted outputs (out_valid=1 and out_rdy=1) in out_cnt, both CNT_W bits, starting at 0.
REQ-015 SHALL implement mark FSM states IDLE, ORIG, DUP, with transitions IDLE->ORIG and ORIG->DUP only.
REQ-016 In IDLE, in_valid=1 and exec_dup=1 SHALL store orig_idx=in_cnt and orig_in=in_data and go to ORIG.
REQ-017 In ORIG, in_valid=1, exec_dup=1 and in_data==orig_in SHALL store dup_idx=in_cnt and go to DUP; exec_dup=1 with unequal data SHALL be ignored.
REQ-018 In DUP, further exec_dup marks SHALL be ignored.
REQ-019 exec_dup with in_valid=0 SHALL be ignored in every state.
REQ-020 An accepted output with out_cnt==orig_idx (state ORIG or DUP) SHALL capture orig_out=out_data and set orig_got; the same rule with dup_idx (state DUP) SHALL capture dup_out and set dup_got.
REQ-021 In the cycle a mark is taken, the index comparison SHALL also use the index being captured (bypass), so an output with the same index in that cycle is captured.
REQ-022 Each of orig_got/dup_got SHALL be set once; later index matches SHALL NOT overwrite captured data.
REQ-023 qed_done SHALL rise exactly one cycle after both orig_got and dup_got are 1 and SHALL stay 1 until reset.
REQ-024 qed_check SHALL be registered as (orig_out==dup_out) in the same cycle qed_done rises and SHALL be held thereafter; it is 0 whenever qed_done=0.
REQ-025 in_cnt and out_cnt SHALL saturate at 2^CNT_W-1; reaching saturation while qed_done=0 SHALL set overflow, and once overflow=1 no further capture SHALL occur and qed_done SHALL stay 0.
REQ-026 Simultaneous input acceptance and output acceptance in one cycle SHALL update both counters independently.

Reset
REQ-027 reset=0 at a rising clk edge SHALL clear in_cnt, out_cnt, orig_idx, dup_idx, orig_in, orig_out, dup_out, orig_got, dup_got, qed_done, qed_check and overflow to 0 and put the FSM in IDLE.
REQ-028 Reset asserted mid-operation, including after qed_done=1, SHALL abandon all captured state; the first cycle after release behaves as a fresh start.

Verification
REQ-029 Inputs 0x11,0x22(mark),0x33,0x22(mark); outputs echo inputs -> orig_idx=1, dup_idx=3, qed_done=1 one cycle after 4th output, qed_check=1.
REQ-030 Same inputs, output 3 corrupted to 0x99 -> qed_done=1, qed_check=0.
REQ-031 Second mark on 0x33 (unequal to 0x22) then mark on 0x22 -> 0x33 mark ignored, dup_idx=3 at the 0x22 position.
REQ-032 Mark on input 0 with output 0 accepted same cycle -> orig_out captured via bypass in that cycle.
REQ-033 out_valid=1, out_rdy=0 for 5 cycles -> out_cnt unchanged, no capture; capture on first cycle with out_rdy=1.
REQ-034 Reset pulsed after qed_done=1 -> all outputs 0 next cycle; new sequence completes correctly; CNT_W=4 with 15 unmarked inputs -> overflow=1, qed_done stays 0.
